// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared types and constants for the branch predictor
package core_pkg;

   localparam int BP_INDEX_W   = 6;
   // Widest tag any legal INDEX_W can need; narrower tags are zero-extended
   localparam int BP_TAG_MAX_W = 30;

   typedef enum logic [1:0] {
      BP_SNT = 2'b00,
      BP_WNT = 2'b01,
      BP_WT  = 2'b10,
      BP_ST  = 2'b11
   } bp_cnt_e;

   localparam bp_cnt_e BP_CNT_RST = BP_WNT;

   typedef struct packed {
      logic                    valid;
      logic [BP_TAG_MAX_W-1:0] tag;
      bp_cnt_e                 cnt;
      logic [31:0]             target;
   } bp_entry_t;

endpackage

// File: rtl/sat_counter2.sv
// rtl/sat_counter2.sv - 2-bit saturating up/down counter, combinational next state
module sat_counter2
   import core_pkg::*;
(
   input  bp_cnt_e cnt_i,
   input  logic    inc_i,
   output bp_cnt_e cnt_o
);

   always_comb begin
      cnt_o = cnt_i;
      if (inc_i) begin
         if (cnt_i != BP_ST) cnt_o = bp_cnt_e'(cnt_i + 2'd1);
      end else begin
         if (cnt_i != BP_SNT) cnt_o = bp_cnt_e'(cnt_i - 2'd1);
      end
   end

endmodule

// File: rtl/two_bit_predictor.sv
// rtl/two_bit_predictor.sv - direct-mapped BHT predictor with EX resolution and perf counters
module two_bit_predictor
   import core_pkg::*;
#(
   parameter int INDEX_W = BP_INDEX_W,
   parameter int TAG_W   = 32 - INDEX_W - 2,
   parameter int CNT_W   = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [31:0]      pc_if_i,
   output logic             pred_taken_o,
   output logic [31:0]      pred_target_o,
   input  logic             ex_valid_i,
   input  logic             ex_stall_i,
   input  logic [31:0]      ex_pc_i,
   input  logic             ex_is_br_i,
   input  logic             ex_taken_i,
   input  logic [31:0]      ex_target_i,
   input  logic             ex_pred_taken_i,
   input  logic [31:0]      ex_pred_target_i,
   output logic             mis_hit_o,
   output logic [31:0]      redirect_pc_o,
   output logic [CNT_W-1:0] br_cnt_o,
   output logic [CNT_W-1:0] miss_cnt_o
);

   localparam int ENTRIES = 1 << INDEX_W;

   bp_entry_t               table_q [ENTRIES];
   logic [CNT_W-1:0]        br_cnt_q, br_cnt_d;
   logic [CNT_W-1:0]        miss_cnt_q, miss_cnt_d;

   logic [INDEX_W-1:0]      if_idx, ex_idx;
   logic [BP_TAG_MAX_W-1:0] if_tag, ex_tag;
   bp_entry_t               if_entry, ex_entry, ex_entry_d;
   logic                    if_hit, ex_hit, upd, active;
   bp_cnt_e                 ex_cnt_nxt;
   logic                    unused_pc_lsbs;

   assign unused_pc_lsbs = ^{pc_if_i[1:0], ex_pc_i[1:0]};

   assign if_idx   = pc_if_i[INDEX_W+1:2];
   assign if_tag   = BP_TAG_MAX_W'(pc_if_i[31:32-TAG_W]);
   assign if_entry = table_q[if_idx];
   assign if_hit   = if_entry.valid && (if_entry.tag == if_tag);

   assign pred_taken_o  = rst_ni && if_hit && if_entry.cnt[1];
   assign pred_target_o = pred_taken_o ? if_entry.target : pc_if_i + 32'd4;

   assign ex_idx   = ex_pc_i[INDEX_W+1:2];
   assign ex_tag   = BP_TAG_MAX_W'(ex_pc_i[31:32-TAG_W]);
   assign ex_entry = table_q[ex_idx];
   assign ex_hit   = ex_entry.valid && (ex_entry.tag == ex_tag);

   assign active = rst_ni && ex_valid_i && !ex_stall_i;
   assign upd    = active && ex_is_br_i;

   // A non-branch carrying a taken prediction hit an aliased entry in IF
   assign mis_hit_o = active &&
                      ((ex_is_br_i && (ex_pred_taken_i != ex_taken_i)) ||
                       (ex_is_br_i && ex_taken_i && ex_pred_taken_i &&
                        (ex_pred_target_i != ex_target_i)) ||
                       (!ex_is_br_i && ex_pred_taken_i));

   assign redirect_pc_o = !rst_ni ? 32'd0 :
                          (ex_is_br_i && ex_taken_i) ? ex_target_i : ex_pc_i + 32'd4;

   sat_counter2 u_sat_counter2 (
      .cnt_i (ex_entry.cnt),
      .inc_i (ex_taken_i),
      .cnt_o (ex_cnt_nxt)
   );

   always_comb begin
      ex_entry_d = ex_entry;
      if (ex_hit) begin
         ex_entry_d.cnt = ex_cnt_nxt;
         if (ex_taken_i) ex_entry_d.target = ex_target_i;
      end else begin
         ex_entry_d.valid  = 1'b1;
         ex_entry_d.tag    = ex_tag;
         ex_entry_d.cnt    = ex_taken_i ? BP_WT : BP_WNT;
         ex_entry_d.target = ex_target_i;
      end
   end

   always_comb begin
      br_cnt_d   = br_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (upd && (br_cnt_q != '1)) br_cnt_d = br_cnt_q + CNT_W'(1);
      if (mis_hit_o && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int i = 0; i < ENTRIES; i++) begin
            table_q[i] <= '{valid: 1'b0, tag: '0, cnt: BP_CNT_RST, target: '0};
         end
         br_cnt_q   <= '0;
         miss_cnt_q <= '0;
      end else begin
         if (upd) table_q[ex_idx] <= ex_entry_d;
         br_cnt_q   <= br_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign br_cnt_o   = br_cnt_q;
   assign miss_cnt_o = miss_cnt_q;

endmodule

// File: doc/two_bit_predictor.md
Name: two_bit_predictor

Overview:
- Dynamic branch predictor for the pipelined RV32I core: a direct-mapped branch history table of 2-bit saturating counters, each entry holding a tag and a target.
- IF-stage lookup supplies the predicted direction and target for the next fetch.
- EX-stage resolution updates the table and raises mis_hit_o, which register_control consumes to flush IF/ID and ID/EX.
- Also keeps branch and mispredict performance counters.

Parameters:
- INDEX_W, 6, log2 of table entries (64 entries); index = pc[INDEX_W+1:2]
- TAG_W, 32-INDEX_W-2, tag bits; tag = pc[31:INDEX_W+2]
- CNT_W, 32, width of each performance counter

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  synchronous active-low reset
- pc_if_i  in  32  fetch PC
- pred_taken_o  out  1  predicted taken for pc_if_i
- pred_target_o  out  32  predicted target; equals pc_if_i+4 when not taken
- ex_valid_i  in  1  EX stage holds a real instruction, not a bubble
- ex_stall_i  in  1  pipeline frozen (register-file wait); blocks the update
- ex_pc_i  in  32  PC of the EX instruction
- ex_is_br_i  in  1  EX instruction is a conditional branch or JAL
- ex_taken_i  in  1  resolved direction
- ex_target_i  in  32  resolved target
- ex_pred_taken_i  in  1  prediction carried down the pipe with the instruction
- ex_pred_target_i  in  32  predicted target carried down the pipe
- mis_hit_o  out  1  misprediction detected in EX
- redirect_pc_o  out  32  correct next PC when mis_hit_o=1
- br_cnt_o  out  CNT_W  resolved branches
- miss_cnt_o  out  CNT_W  mispredictions

Behaviour:
- Counter encoding: 00 SNT, 01 WNT, 10 WT, 11 ST. Predict taken iff counter[1]=1.
- Each entry: valid, tag[TAG_W], cnt[1:0], target[32].
- Lookup is combinational (same cycle):
  - hit = valid && tag match.
  - pred_taken_o = hit && cnt[1].
  - pred_target_o = pred_taken_o ? entry target : pc_if_i+4.
- Reset, while rst_ni=0 at a rising edge:
  - All valid bits clear, all cnt=01, targets and tags=0, both perf counters=0.
  - Outputs forced combinationally while rst_ni=0: pred_taken_o=0, pred_target_o=pc_if_i+4, mis_hit_o=0, redirect_pc_o=0.
  - A reset asserted mid-operation discards all history at the next edge. No partial update.
- Update enable: upd = ex_valid_i && !ex_stall_i && ex_is_br_i && rst_ni. Writes occur at the clock edge.
- On upd with hit at the ex_pc_i entry:
  - Saturating inc if taken (11 stays 11); saturating dec if not taken (00 stays 00).
  - Target overwritten with ex_target_i only if taken.
- On upd with miss:
  - Allocate/replace the entry: valid=1, tag written.
  - cnt = taken ? 10 : 01.
  - target = ex_target_i.
- Non-branch or bubble: no table write.
- mis_hit_o (combinational), asserted when ex_valid_i && !ex_stall_i && any of:
  - ex_is_br_i && (ex_pred_taken_i != ex_taken_i)
  - ex_is_br_i && ex_taken_i && ex_pred_taken_i && (ex_pred_target_i != ex_target_i)
  - !ex_is_br_i && ex_pred_taken_i (stale alias prediction)
- redirect_pc_o = (ex_is_br_i && ex_taken_i) ? ex_target_i : ex_pc_i+4.
- Perf counters:
  - br_cnt_o increments on upd.
  - miss_cnt_o increments when mis_hit_o=1 at an edge.
  - Both saturate at all-ones; no wrap.
- Same-cycle lookup and update of the same index: the lookup returns pre-update contents (no bypass). The new value is visible the next cycle.
- Latency: prediction 0 cycles; table update visible 1 cycle after resolution; mis_hit_o 0 cycles (the register_control flush lands at the next edge).
- ex_stall_i=1 holds the table and perf counters unchanged and suppresses mis_hit_o, so the flush is not double-counted while frozen.

Decomposition:
- Shared package core_pkg:
  - Typedef bp_cnt_e for SNT/WNT/WT/ST.
  - Typedef bp_entry_t {valid, tag, cnt, target}.
  - Constants BP_INDEX_W and BP_CNT_RST=WNT.
- Sub-module sat_counter2: 2-bit saturating inc/dec, combinational next-state.
- The table array, lookup, mispredict logic and perf counters stay in two_bit_predictor.

Test Plan:
- Reset held 2 cycles, then pc_if_i=0x100 -> pred_taken_o=0, pred_target_o=0x104, br_cnt_o=0, miss_cnt_o=0.
- Branch at 0x100 resolves taken to 0x80 with ex_pred_taken_i=0 -> mis_hit_o=1, redirect_pc_o=0x80. Next cycle pc_if_i=0x100 gives pred_taken_o=1, pred_target_o=0x80, miss_cnt_o=1.
- Saturation: same branch taken 3 more times (cnt 10->11->11), then not-taken once -> still predicts taken (cnt=10); second not-taken -> predicts not taken (cnt=01).
- Aliasing: 0x100 trained taken, then branch at 0x1100 (same index, different tag) resolves not-taken -> entry replaced with cnt=01. Lookup of 0x100 -> pred_taken_o=0.
- Wrong target: ex_pred_taken_i=1, ex_pred_target_i=0x80, ex_target_i=0x90, taken -> mis_hit_o=1, redirect_pc_o=0x90, stored target becomes 0x90.
- Stall/reset: mispredicting branch with ex_stall_i=1 -> mis_hit_o=0, counters unchanged. Then rst_ni=0 for one cycle after training -> all lookups predict not taken.
